// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus widths, chip-enable levels, PC increment.
// Imported by inst_fetch_unit and if_skid_fifo.
package inst_fetch_unit_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;   // InstAddrBus
  localparam int unsigned INST_BUS_W      = 32;   // InstBus
  localparam int unsigned PC_INCR         = 4;    // bytes per instruction
  localparam int unsigned FIFO_DEPTH      = 2;
  localparam int unsigned FIFO_CNT_W      = 2;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

endpackage

// File: rtl/inst_fetch_unit_skid_fifo.sv
// if_skid_fifo: 2-entry FIFO with registered head, push/pop/flush.
// Entry 0 is always the head, so head outputs come straight from flops.
// Ports: clk, rst_n (async active-low), push_i, pop_i, flush_i, wdata_i,
//        count_o, head_valid_o, head_data_o.
module if_skid_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output fifo_cnt_t         count_o,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o
);

  fifo_cnt_t         count_q, count_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] e0_q, e0_d;
  logic [DATA_W-1:0] e1_q, e1_d;
  logic              pop_ok_c;
  logic              push_ok_c;
  logic              wr_e0_c;

  // Next-state: flush wins; a pop shifts entry 1 forward before the tail write.
  always_comb begin
    count_d   = count_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    pop_ok_c  = pop_i & (count_q != fifo_cnt_t'(0));
    push_ok_c = push_i & ((count_q < fifo_cnt_t'(FIFO_DEPTH)) | pop_ok_c);
    wr_e0_c   = (count_q == fifo_cnt_t'(0)) |
                ((count_q == fifo_cnt_t'(1)) & pop_ok_c);
    if (flush_i) begin
      count_d = fifo_cnt_t'(0);
    end else begin
      if (pop_ok_c) begin
        e0_d = e1_q;
      end
      if (push_ok_c) begin
        if (wr_e0_c) begin
          e0_d = wdata_i;
        end else begin
          e1_d = wdata_i;
        end
      end
      count_d = count_q + fifo_cnt_t'(push_ok_c) - fifo_cnt_t'(pop_ok_c);
    end
    valid_d = (count_d != fifo_cnt_t'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q;
  assign head_data_o  = e0_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM, buffers {pc, inst}
// pairs in a 2-entry skid FIFO toward decode; branch redirect flushes.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt_o / perf_stall_cnt_o.
// Ports: clk, rst (async active-low), rom_addr_o, rom_ce_o, rom_data_i,
//        branch_flag_i, branch_target_i, if_valid_o, if_pc_o, if_inst_o,
//        id_ready_i [, perf_fetch_cnt_o, perf_stall_cnt_o].
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS_W,
  parameter int unsigned       INST_W   = INST_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o,
`endif
  input  logic              id_ready_i
);

  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               rom_ce_q, rom_ce_d;
  logic               pop_c;
  logic               push_c;
  fifo_cnt_t          count;
  logic               head_valid;
  logic [ENTRY_W-1:0] head_data;

  assign pop_c  = head_valid & id_ready_i;
  assign push_c = rom_ce_q & ~branch_flag_i &
                  ((count < fifo_cnt_t'(FIFO_DEPTH)) | pop_c);

  // PC next-state: redirect > push-advance > hold (full buffer re-reads).
  always_comb begin
    pc_d     = pc_q;
    rom_ce_d = CHIP_ENABLE;
    if (branch_flag_i) begin
      pc_d = {branch_target_i[ADDR_W-1:2], 2'b00};
    end else if (push_c) begin
      pc_d = pc_q + ADDR_W'(PC_INCR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rom_ce_q <= CHIP_DISABLE;
    end else begin
      pc_q     <= pc_d;
      rom_ce_q <= rom_ce_d;
    end
  end

  // Redirect leaves the head unconsumed, so pop is masked by the branch.
  if_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_skid_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push_c),
    .pop_i        (pop_c & ~branch_flag_i),
    .flush_i      (branch_flag_i),
    .wdata_i      ({pc_q, rom_data_i}),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_data_o  (head_data)
  );

  assign rom_addr_o = pc_q;
  assign rom_ce_o   = rom_ce_q;
  assign if_valid_o = head_valid;
  assign if_pc_o    = head_data[ENTRY_W-1:INST_W];
  assign if_inst_o  = head_data[INST_W-1:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall = ROM enabled but nothing accepted and no redirect.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push_c) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (rom_ce_q & ~push_c & ~branch_flag_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: table of per-cycle vectors plus
// hand-written sequences for reset mid-stream, PC wrap and perf counters.
module tb_inst_fetch_unit;

  localparam logic [31:0] ROM_XOR = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] rom_data;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total;
  int bad;

  inst_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .rom_addr_o      (rom_addr),
    .rom_ce_o        (rom_ce),
    .rom_data_i      (rom_data),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .if_valid_o      (if_valid),
    .if_pc_o         (if_pc),
    .if_inst_o       (if_inst),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt_o(perf_fetch_cnt),
    .perf_stall_cnt_o(perf_stall_cnt),
`endif
    .id_ready_i      (id_ready)
  );

  // ROM model: word content derived from its address.
  assign rom_data = rom_addr ^ ROM_XOR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] hpc;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and release 1 time unit after an edge.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    id_ready = 1'b0;
    branch_flag = 1'b0;
    branch_target = '0;

    //          rdy   br    tgt           ce    addr          vld   head pc
    tv[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    tv[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    tv[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
    tv[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0};
    tv[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0};
    tv[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0};
    tv[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0};
    tv[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4};
    tv[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h8};
    tv[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'hC};
    tv[10] = '{1'b1, 1'b1, 32'h103,      1'b1, 32'h14,       1'b1, 32'hC};
    tv[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0};
    tv[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h100};
    tv[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h104};

    // Reset state while held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_ce",    32'(rom_ce),   32'h0);
    chk("rst_addr",  rom_addr,      32'h0);
    chk("rst_pc",    if_pc,         32'h0);
    chk("rst_inst",  if_inst,       32'h0);
    rst = 1'b1;

    // Vector i: inputs during cycle i, registered outputs seen in cycle i.
    for (int i = 0; i < 14; i++) begin
      id_ready      = tv[i].rdy;
      branch_flag   = tv[i].br;
      branch_target = tv[i].tgt;
      chk($sformatf("v%0d_ce", i),    32'(rom_ce),   32'(tv[i].ce));
      chk($sformatf("v%0d_addr", i),  rom_addr,      tv[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("v%0d_pc", i),   if_pc,   tv[i].hpc);
        chk($sformatf("v%0d_inst", i), if_inst, tv[i].hpc ^ ROM_XOR);
      end
      step();
    end
    branch_flag = 1'b0;

    // Fill buffer, then async reset mid-cycle.
    id_ready = 1'b0;
    step();
    step();
    chk("full_valid", 32'(if_valid), 32'h1);
    chk("full_pc",    if_pc,         32'h108);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(if_valid), 32'h0);
    chk("async_ce",    32'(rom_ce),   32'h0);
    chk("async_addr",  rom_addr,      32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    id_ready = 1'b1;
    chk("rs0_ce", 32'(rom_ce), 32'h0);
    step();
    chk("rs1_ce",    32'(rom_ce),   32'h1);
    chk("rs1_valid", 32'(if_valid), 32'h0);
    step();
    chk("rs2_valid", 32'(if_valid), 32'h1);
    chk("rs2_pc",    if_pc,         32'h0);
    chk("rs2_addr",  rom_addr,      32'h4);
    step();
    chk("rs3_pc",    if_pc,         32'h4);

    // PC wrap: redirect to top word, fetch across 2^32.
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    step();
    branch_flag = 1'b0;
    chk("wrap_addr0",  rom_addr,      32'hFFFF_FFFC);
    chk("wrap_valid0", 32'(if_valid), 32'h0);
    step();
    chk("wrap_addr1",  rom_addr,      32'h0);
    chk("wrap_pc1",    if_pc,         32'hFFFF_FFFC);
    chk("wrap_inst1",  if_inst,       32'hFFFF_FFFC ^ ROM_XOR);
    step();
    chk("wrap_addr2",  rom_addr,      32'h4);
    chk("wrap_pc2",    if_pc,         32'h0);

`ifdef IF_PERF_CNT_EN
    // 10 pushes (cycles 1..10), then 3 full-buffer stall cycles.
    id_ready = 1'b1;
    do_reset();
    chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
    for (int i = 0; i < 10; i++) step();
    id_ready = 1'b0;
    repeat (4) step();
    chk("perf_fetch", perf_fetch_cnt, 32'd10);
    chk("perf_stall", perf_stall_cnt, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
